mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O peripheral on the CPU data bus, in the I/O region (addr[8]=1).
- Replaces the ad-hoc switch read mux. Provides debounced SW and KEY[3:1] inputs, a KEY press-capture register, LED and HEX output registers, and a free-running timer.
- Downstream of the CPU store path and upstream of the CPU load mux: read data feeds ReadData whenever addr[8]=1.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new input level (10 ms at 50 MHz). Benches use 4.
- CNT_W, 19: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50, input, 1: clock. All logic is in this domain.
- reset, input, 1: synchronous, active-high.
- addr, input, 32: CPU byte address. Only addr[8] and addr[7:2] are decoded.
- wdata, input, 32: store data.
- we, input, 1: store strobe, one cycle per store, qualified by addr[8].
- rdata, output, 32: combinational load data for the current addr.
- sw_raw, input, 10: board switches, asynchronous.
- key_raw_n, input, 3: KEY[3:1], asynchronous, active-low.
- led, output, 10: LED register.
- hex_value, output, 24: six nibbles for the display decoders. Nibble 0 drives HEX0.

Behaviour:
- Address decode:
  - Selected when addr[8]=1. Offset = addr[7:2].
  - Writes with addr[8]=0 are ignored. rdata=0 when addr[8]=0 or the offset is unmapped.
- Register map (byte address):
  - 0x100 LED, RW, bits[9:0].
  - 0x104 HEX, RW, bits[23:0].
  - 0x108 KEYSTAT, RO: debounced key level, 1 = pressed.
  - 0x10C KEYEDGE, RW1C, bits[2:0].
  - 0x110 TIMER, RO, 32-bit.
  - 0x114 TCTRL: bit0 enable (RW), bit1 clear (write-only, reads 0).
  - 0x120 SW, RO: debounced switches.
- Reset: led=0, hex_value=0, KEYEDGE=0, TIMER=0, enable=0, all synchronizers=0.
  - Debounced SW resets to 0. Debounced key level resets to 0 (not pressed).
  - All debounce counters reset to 0.
- Write side:
  - Register writes take effect on the CLOCK_50 edge where we=1. New value is visible on rdata the next cycle.
  - Writes to RO offsets have no effect.
- Input path: each raw bit passes through a 2-FF synchronizer; keys are inverted after synchronization.
- Debounce, per bit:
  - If synced value equals the stable value, the counter is set to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter returns to 0.
  - Any return to the stable value before that restarts the count.
  - Latency from raw change to stable change is exactly 2+DEBOUNCE_CYCLES cycles for a clean step.
- KEYEDGE:
  - A bit sets on the cycle after its debounced key rises 0->1.
  - Writing 1 to a bit clears it. Writing 0 has no effect.
  - If a set and a clear land in the same cycle, the set wins.
  - Releases never set a bit.
- TIMER:
  - Increments by 1 each cycle while enable=1. Wraps from 0xFFFFFFFF to 0.
  - A write with bit1=1 zeroes TIMER on that edge, regardless of enable.
  - If that same write also sets enable=1, counting starts the next cycle (TIMER reads 0, then 1).
- Reset during a debounce window discards partial counts. Reset has priority over writes.

Decomposition:
- Package mmio_io_pkg holds:
  - localparam byte offsets: OFF_LED, OFF_HEX, OFF_KEYSTAT, OFF_KEYEDGE, OFF_TIMER, OFF_TCTRL, OFF_SW.
  - IO_REGION_BIT=8.
  - TCTRL bit indices.
- Sub-module io_debounce, parameterised by WIDTH, DEBOUNCE_CYCLES and CNT_W. It holds the synchronizer, per-bit counters and the stable register.
  - Instantiated twice: WIDTH=10 for SW, WIDTH=3 for keys.
  - Key inversion happens outside it.

Test Plan:
- Reset, then read every offset -> all return 0. Read 0x118 -> 0. Write 0x10 to 0x0FC (addr[8]=0) -> led stays 0.
- Write 0x3A5 to 0x100 and 0xABCDEF to 0x104 -> next cycle led=0x3A5, hex_value=0xABCDEF, and reads return the same values. Write to 0x110 -> TIMER unaffected.
- DEBOUNCE_CYCLES=4, sw_raw 0->0x201:
  - SW reads 0x201 exactly 6 cycles later.
  - A 3-cycle glitch on sw_raw[0] never reaches SW.
- key_raw_n[1] driven low and held:
  - KEYSTAT=0x2, then KEYEDGE=0x2.
  - Release -> KEYEDGE stays 0x2.
  - Write 0x2 to 0x10C -> KEYEDGE=0.
  - Write 0x2 on the same cycle as a new press edge -> KEYEDGE stays 0x2.
- Write 0x1 to 0x114, wait 10 cycles -> TIMER=10.
  - Write 0x3 -> TIMER reads 0, then 1.
  - Write 0x0 -> TIMER holds.
  - Force TIMER to 0xFFFFFFFF, enable -> TIMER reads 0 next cycle.
- Assert reset mid-debounce with sw_raw changed -> SW=0 after reset. A new 6-cycle settle is required after reset deasserts.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// mmio_io_pkg: shared constants for the memory-mapped I/O controller.
//   - Byte offsets of each register inside the I/O region (addr[7:0]).
//   - Address bit that selects the I/O region.
//   - Bit positions inside the timer control register.
//   - Field widths of the board-facing registers.
package mmio_io_pkg;

    localparam int IO_REGION_BIT = 8;

    localparam logic [7:0] OFF_LED     = 8'h00;
    localparam logic [7:0] OFF_HEX     = 8'h04;
    localparam logic [7:0] OFF_KEYSTAT = 8'h08;
    localparam logic [7:0] OFF_KEYEDGE = 8'h0C;
    localparam logic [7:0] OFF_TIMER   = 8'h10;
    localparam logic [7:0] OFF_TCTRL   = 8'h14;
    localparam logic [7:0] OFF_SW      = 8'h20;

    localparam int TCTRL_EN_BIT  = 0;
    localparam int TCTRL_CLR_BIT = 1;

    localparam int LED_W = 10;
    localparam int HEX_W = 24;
    localparam int KEY_W = 3;
    localparam int SW_W  = 10;

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: CPU data-bus slice seen by the I/O controller.
//   addr  : byte address from the CPU
//   wdata : store data
//   we    : one-cycle store strobe
//   rdata : combinational load data returned by the peripheral
// master = CPU side, slave = peripheral side.
interface mmio_io_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// io_debounce: 2-FF synchronizer followed by a per-bit debounce filter.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high
//   raw_i    : asynchronous input bits (already in "1 = active" polarity)
//   stable_o : debounced level, changes only after DEBOUNCE_CYCLES
//              consecutive cycles of a new synchronized level
module io_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o
);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // A bit whose synced level disagrees with the stable level counts up;
    // any agreement restarts the window, so only an unbroken run flips it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O peripheral in the addr[8]=1 region.
//   CLOCK_50  : clock
//   reset     : synchronous, active-high
//   bus       : CPU data bus (slave side): addr, wdata, we in; rdata out
//   sw_raw    : board switches, asynchronous
//   key_raw_n : KEY[3:1], asynchronous, active-low
//   led       : LED register
//   hex_value : six display nibbles, nibble 0 drives HEX0
// Registers: LED, HEX (RW), KEYSTAT (RO), KEYEDGE (RW1C), TIMER (RO),
// TCTRL (enable RW, clear write-only), SW (RO).
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    mmio_io_ctrl_if.slave     bus,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [KEY_W-1:0]  key_raw_n,
    output logic [LED_W-1:0]  led,
    output logic [HEX_W-1:0]  hex_value
);

    logic [LED_W-1:0] led_q, led_d;
    logic [HEX_W-1:0] hex_q, hex_d;
    logic [KEY_W-1:0] kedge_q, kedge_d;
    logic [KEY_W-1:0] kprev_q;
    logic [31:0]      timer_q, timer_d;
    logic             ten_q, ten_d;

    logic [SW_W-1:0]  sw_lvl;
    logic [KEY_W-1:0] key_lvl;
    logic             sel, wr;
    logic [7:0]       off;
    logic [31:0]      rdata_c;
    logic             unused_bits;

    assign sel = bus.addr[IO_REGION_BIT];
    assign off = {bus.addr[7:2], 2'b00};
    assign wr  = bus.we & sel;

    assign unused_bits = ^{bus.addr[31:9], bus.addr[1:0], bus.wdata[31:24]};

    io_debounce #(
        .WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_sw_db (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw_i    (sw_raw),
        .stable_o (sw_lvl)
    );

    // Keys are flipped ahead of the synchronizer so that the all-zero
    // reset state of the filter already means "not pressed"; the timing
    // is identical to inverting the synchronized value.
    io_debounce #(
        .WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_key_db (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw_i    (~key_raw_n),
        .stable_o (key_lvl)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            led_q   <= '0;
            hex_q   <= '0;
            kedge_q <= '0;
            kprev_q <= '0;
            timer_q <= '0;
            ten_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            hex_q   <= hex_d;
            kedge_q <= kedge_d;
            kprev_q <= key_lvl;
            timer_q <= timer_d;
            ten_q   <= ten_d;
        end
    end

    always_comb begin
        led_d   = led_q;
        hex_d   = hex_q;
        ten_d   = ten_q;
        timer_d = ten_q ? timer_q + 32'd1 : timer_q;

        if (wr && off == OFF_LED) led_d = bus.wdata[LED_W-1:0];
        if (wr && off == OFF_HEX) hex_d = bus.wdata[HEX_W-1:0];
        if (wr && off == OFF_TCTRL) begin
            ten_d = bus.wdata[TCTRL_EN_BIT];
            // The new enable only matters from the next edge, so a
            // clear+enable write reads 0 first and then 1.
            if (bus.wdata[TCTRL_CLR_BIT]) timer_d = '0;
        end

        // Clear first, then OR the rising edges so a simultaneous press wins.
        kedge_d = kedge_q;
        if (wr && off == OFF_KEYEDGE) kedge_d = kedge_q & ~bus.wdata[KEY_W-1:0];
        kedge_d = kedge_d | (key_lvl & ~kprev_q);
    end

    always_comb begin
        rdata_c = '0;
        if (sel) begin
            case (off)
                OFF_LED:     rdata_c[LED_W-1:0] = led_q;
                OFF_HEX:     rdata_c[HEX_W-1:0] = hex_q;
                OFF_KEYSTAT: rdata_c[KEY_W-1:0] = key_lvl;
                OFF_KEYEDGE: rdata_c[KEY_W-1:0] = kedge_q;
                OFF_TIMER:   rdata_c            = timer_q;
                OFF_TCTRL:   rdata_c[TCTRL_EN_BIT] = ten_q;
                OFF_SW:      rdata_c[SW_W-1:0]  = sw_lvl;
                default:     rdata_c            = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;
    assign led       = led_q;
    assign hex_value = hex_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [2:0]  key_raw_n;
    logic [9:0]  led;
    logic [23:0] hex_value;

    int checks = 0;
    int errors = 0;

    mmio_io_ctrl_if bus();

    always #5 CLOCK_50 = ~CLOCK_50;

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .bus       (bus),
        .sw_raw    (sw_raw),
        .key_raw_n (key_raw_n),
        .led       (led),
        .hex_value (hex_value)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // One store: strobe is high across exactly one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(negedge CLOCK_50);
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] offs [9];
        offs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                 32'h114, 32'h120, 32'h118, 32'h11C};
        reset = 1'b1; sw_raw = '0; key_raw_n = 3'b111;
        bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rd(offs[i], v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL reset_rd[%h]: got %h want 0", offs[i], v);
            end
            tick(1);
        end
        wr(32'h0FC, 32'h10);
        wr(32'h000, 32'h10);
        checks++;
        if (led !== 10'h0) begin
            errors++; $display("FAIL low_region_wr: led got %h want 0", led);
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        wr(32'h100, 32'h3A5);
        wr(32'h104, 32'hABCDEF);
        checks++;
        if (led !== 10'h3A5) begin
            errors++; $display("FAIL led_port: got %h want 3a5", led);
        end
        checks++;
        if (hex_value !== 24'hABCDEF) begin
            errors++; $display("FAIL hex_port: got %h want abcdef", hex_value);
        end
        rd(32'h100, v);
        checks++;
        if (v !== 32'h3A5) begin
            errors++; $display("FAIL led_rd: got %h want 3a5", v);
        end
        rd(32'h104, v);
        checks++;
        if (v !== 32'hABCDEF) begin
            errors++; $display("FAIL hex_rd: got %h want abcdef", v);
        end
        rd(32'h000, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL low_region_rd: got %h want 0", v);
        end
        wr(32'h110, 32'h1234);
        rd(32'h110, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL timer_ro: got %h want 0", v);
        end
        wr(32'h100, 32'hFFFF_FFFF);
        rd(32'h100, v);
        checks++;
        if (v !== 32'h3FF) begin
            errors++; $display("FAIL led_width: got %h want 3ff", v);
        end
    endtask

    task automatic test_sw_debounce();
        logic [31:0] v;
        sw_raw = 10'h201;
        tick(5);
        rd(32'h120, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL sw_early: got %h want 0", v);
        end
        tick(1);
        rd(32'h120, v);
        checks++;
        if (v !== 32'h201) begin
            errors++; $display("FAIL sw_settle: got %h want 201", v);
        end
        // 3-cycle low pulse on bit 0 must be filtered out.
        sw_raw = 10'h200;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 2) sw_raw = 10'h201;
            rd(32'h120, v);
            checks++;
            if (v !== 32'h201) begin
                errors++; $display("FAIL sw_glitch[%0d]: got %h want 201", i, v);
            end
        end
    endtask

    task automatic test_keys();
        logic [31:0] v;
        key_raw_n = 3'b101;
        tick(5);
        rd(32'h108, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL keystat_early: got %h want 0", v);
        end
        tick(1);
        rd(32'h108, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL keystat: got %h want 2", v);
        end
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL keyedge_early: got %h want 0", v);
        end
        tick(1);
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL keyedge_set: got %h want 2", v);
        end
        key_raw_n = 3'b111;
        tick(8);
        rd(32'h108, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL keystat_release: got %h want 0", v);
        end
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL keyedge_release: got %h want 2", v);
        end
        wr(32'h10C, 32'h0);
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL keyedge_w0: got %h want 2", v);
        end
        wr(32'h10C, 32'h2);
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL keyedge_w1c: got %h want 0", v);
        end
        // New press: clear lands on the same edge as the set.
        key_raw_n = 3'b101;
        tick(6);
        wr(32'h10C, 32'h2);
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL keyedge_set_wins: got %h want 2", v);
        end
        key_raw_n = 3'b111;
        tick(8);
        wr(32'h10C, 32'h7);
        rd(32'h10C, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL keyedge_final_clr: got %h want 0", v);
        end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        wr(32'h114, 32'h1);
        tick(10);
        rd(32'h110, v);
        checks++;
        if (v !== 32'd10) begin
            errors++; $display("FAIL timer_count: got %0d want 10", v);
        end
        rd(32'h114, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL tctrl_rd: got %h want 1", v);
        end
        wr(32'h114, 32'h3);
        rd(32'h110, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL timer_clr: got %0d want 0", v);
        end
        tick(1);
        rd(32'h110, v);
        checks++;
        if (v !== 32'd1) begin
            errors++; $display("FAIL timer_after_clr: got %0d want 1", v);
        end
        // Enable is still 1 on the disabling edge, so one last increment.
        wr(32'h114, 32'h0);
        tick(3);
        rd(32'h110, v);
        checks++;
        if (v !== 32'd2) begin
            errors++; $display("FAIL timer_hold: got %0d want 2", v);
        end
        wr(32'h114, 32'h2);
        rd(32'h110, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL timer_clr_disabled: got %0d want 0", v);
        end
        force dut.timer_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.timer_q;
        wr(32'h114, 32'h1);
        rd(32'h110, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL timer_preset: got %h want ffffffff", v);
        end
        tick(1);
        rd(32'h110, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL timer_wrap: got %h want 0", v);
        end
        tick(1);
        rd(32'h110, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL timer_post_wrap: got %h want 1", v);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] v;
        sw_raw = 10'h0AA;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(32'h120, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL sw_after_reset: got %h want 0", v);
        end
        checks++;
        if (led !== 10'h0 || hex_value !== 24'h0) begin
            errors++; $display("FAIL regs_after_reset: led %h hex %h want 0", led, hex_value);
        end
        tick(5);
        rd(32'h120, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL sw_resettle_early: got %h want 0", v);
        end
        tick(1);
        rd(32'h120, v);
        checks++;
        if (v !== 32'h0AA) begin
            errors++; $display("FAIL sw_resettle: got %h want 0aa", v);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_sw_debounce();
        test_keys();
        test_timer();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
